// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: ownership state encoding.
package dmem_arbiter_pkg;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } own_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between the MEM stage (default owner) and a debug/loader port.
// DBG acks 1 cycle after request when CPU idle, at most MAX_WAIT+1 when busy; CPU stalls while DBG owns.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          dbg_lock,
    input  logic [AW-1:0] dbg_a,
    input  logic [DW-1:0] dbg_wd,
    output logic          dbg_ack,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int unsigned WW = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT + 1)  : 1;
    localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    own_t          state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          sel_dbg;
    logic          dbg_rd_hit;

    // State register and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= OWN_CPU;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        burst_nxt = burst_cnt;
        case (state)
            OWN_CPU: begin
                if (!dbg_req) begin
                    wait_nxt = '0;
                end else if (cpu_req && (wait_cnt < WAIT_MAX)) begin
                    wait_nxt = wait_cnt + 1'b1;
                end else begin
                    state_nxt = OWN_DBG;
                    wait_nxt  = '0;
                    burst_nxt = '0;
                end
            end
            OWN_DBG: begin
                if (dbg_req) begin
                    burst_nxt = burst_cnt + 1'b1;
                end
                // Lock only extends ownership while the burst budget has room for another beat.
                if (!(dbg_req && dbg_lock && (burst_cnt < BURST_LAST))) begin
                    state_nxt = OWN_CPU;
                end
            end
            default: state_nxt = OWN_CPU;
        endcase
    end

    // Output mux: select taken from the state register only, never from dbg_req.
    always_comb begin
        sel_dbg   = (state == OWN_DBG);
        mem_a     = sel_dbg ? dbg_a  : cpu_a;
        mem_wd    = sel_dbg ? dbg_wd : cpu_wd;
        mem_we    = !reset && (sel_dbg ? (dbg_req && dbg_we) : (cpu_req && cpu_we));
        dbg_ack   = sel_dbg && dbg_req;
        cpu_stall = sel_dbg && cpu_req;
        cpu_rd    = mem_rd;
    end

    assign dbg_rd_hit = dbg_ack && !dbg_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rvalid <= 1'b0;
            dbg_rd     <= '0;
        end else begin
            dbg_rvalid <= dbg_rd_hit;
            if (dbg_rd_hit) begin
                dbg_rd <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port dmem behind it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_stall;
    logic [31:0] cpu_a, cpu_wd, cpu_rd;
    logic        dbg_req, dbg_we, dbg_lock, dbg_ack, dbg_rvalid;
    logic [31:0] dbg_a, dbg_wd, dbg_rd;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [64];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_a(dbg_a),
        .dbg_wd(dbg_wd), .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cwd;
        logic        dr, dw, dl;
        logic [31:0] da, dwd;
        logic        e_stall, e_ack, e_we;
        logic [31:0] e_a, e_cpu_rd;
        logic        e_rv;
        logic [31:0] e_drd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[11];
        int   waited, b, run, nruns;
        int   runs[4];
        bit   got, stall_err;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        // Reset with a CPU write presented: mem_we must stay low.
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h10; cpu_wd = 32'hDEADBEEF;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_a = 32'h0; dbg_wd = 32'h0;
        #3;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_ack", dbg_ack, 0);
        chk("rst_rvalid", dbg_rvalid, 0);
        chk("rst_dbg_rd", dbg_rd, 0);
        @(posedge clk);
        tick();
        rst = 1'b0;

        //          cr cw ca     cwd           dr dw dl da     dwd           st ak we a      cpu_rd        rv drd
        vecs[0]  = '{0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 32'h0};
        vecs[1]  = '{1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 32'h10, 32'h0,        0, 32'h0};
        vecs[2]  = '{1, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0};
        vecs[3]  = '{0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 32'h0};
        vecs[4]  = '{0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h10, 32'h0,        0, 1, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0};
        vecs[5]  = '{0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        1, 32'hDEADBEEF};
        vecs[6]  = '{0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 32'hDEADBEEF};
        vecs[7]  = '{0, 0, 32'h10, 32'h0,        1, 1, 1, 32'h20, 32'h11111111, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0, 32'hDEADBEEF};
        vecs[8]  = '{0, 0, 32'h10, 32'h0,        1, 1, 1, 32'h20, 32'h11111111, 0, 1, 1, 32'h20, 32'h0,        0, 32'hDEADBEEF};
        vecs[9]  = '{1, 0, 32'h20, 32'h0,        0, 1, 1, 32'h20, 32'h11111111, 1, 0, 0, 32'h20, 32'h11111111, 0, 32'hDEADBEEF};
        vecs[10] = '{1, 0, 32'h20, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h20, 32'h11111111, 0, 32'hDEADBEEF};

        for (int i = 0; i < 11; i++) begin
            cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_a = vecs[i].ca; cpu_wd = vecs[i].cwd;
            dbg_req = vecs[i].dr; dbg_we = vecs[i].dw; dbg_lock = vecs[i].dl;
            dbg_a = vecs[i].da; dbg_wd = vecs[i].dwd;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i),  cpu_stall,  vecs[i].e_stall);
            chk($sformatf("v%0d_ack", i),    dbg_ack,    vecs[i].e_ack);
            chk($sformatf("v%0d_mem_we", i), mem_we,     vecs[i].e_we);
            chk($sformatf("v%0d_mem_a", i),  mem_a,      vecs[i].e_a);
            chk($sformatf("v%0d_cpu_rd", i), cpu_rd,     vecs[i].e_cpu_rd);
            chk($sformatf("v%0d_rvalid", i), dbg_rvalid, vecs[i].e_rv);
            chk($sformatf("v%0d_dbg_rd", i), dbg_rd,     vecs[i].e_drd);
            tick();
        end

        // Busy CPU: DBG read forced in after MAX_WAIT extra cycles.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b0; dbg_a = 32'h20;
        waited = 0; got = 1'b0; stall_err = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (dbg_ack) got = 1'b1;
            else begin
                if (cpu_stall) stall_err = 1'b1;
                waited++;
                tick();
            end
        end
        chk("force_ack_seen", 32'(got), 1);
        chk("force_wait_cycles", waited, 5);
        chk("force_no_early_stall", 32'(stall_err), 0);
        chk("force_stall_on_beat", cpu_stall, 1);
        chk("force_mem_a", mem_a, 32'h20);
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        chk("force_after_stall", cpu_stall, 0);
        chk("force_after_ack", dbg_ack, 0);
        chk("force_rvalid", dbg_rvalid, 1);
        chk("force_dbg_rd", dbg_rd, 32'h11111111);
        chk("force_cpu_rd", cpu_rd, 32'hDEADBEEF);
        tick();

        // Locked burst of 10 writes against a busy CPU: capped at MAX_BURST beats.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h10;
        dbg_lock = 1'b1; dbg_we = 1'b1;
        b = 0; run = 0; nruns = 0;
        for (int i = 0; i < 4; i++) runs[i] = 0;
        for (int cyc = 0; cyc < 100 && b < 10; cyc++) begin
            dbg_req = 1'b1; dbg_a = 32'(b * 4); dbg_wd = 32'hA0 + 32'(b);
            @(negedge clk);
            if (dbg_ack) begin
                run++;
                b++;
            end else if (run > 0) begin
                if (nruns == 0) begin
                    chk("burst_gap_stall", cpu_stall, 0);
                    chk("burst_gap_cpu_rd", cpu_rd, 32'hA4);
                end
                if (nruns < 4) runs[nruns] = run;
                nruns++;
                run = 0;
            end
            tick();
        end
        if (run > 0 && nruns < 4) begin
            runs[nruns] = run;
            nruns++;
        end
        dbg_req = 1'b0;
        chk("burst_beats", b, 10);
        chk("burst_runs", nruns, 2);
        chk("burst_run0", runs[0], 8);
        chk("burst_run1", runs[1], 2);
        for (int i = 0; i < 10; i++) chk($sformatf("burst_mem%0d", i), mem[i], 32'hA0 + 32'(i));
        @(negedge clk);
        chk("burst_withdraw_ack", dbg_ack, 0);
        chk("burst_withdraw_we", mem_we, 0);
        tick();

        // Asynchronous reset in the middle of a locked burst.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 32'h0;
        dbg_lock = 1'b1; dbg_we = 1'b1;
        b = 0;
        for (int cyc = 0; cyc < 100 && b < 3; cyc++) begin
            dbg_req = 1'b1; dbg_a = 32'h40 + 32'(b * 4); dbg_wd = 32'hB0 + 32'(b);
            @(negedge clk);
            if (dbg_ack) b++;
            tick();
        end
        chk("rstb_beats", b, 3);
        dbg_a = 32'h4C; dbg_wd = 32'hB3;
        #2;
        chk("rstb_pre_ack", dbg_ack, 1);
        chk("rstb_pre_stall", cpu_stall, 1);
        rst = 1'b1;
        #1;
        chk("rstb_stall", cpu_stall, 0);
        chk("rstb_ack", dbg_ack, 0);
        chk("rstb_mem_we", mem_we, 0);
        chk("rstb_rvalid", dbg_rvalid, 0);
        tick();
        rst = 1'b0;
        dbg_req = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("rstb_mem%0d", i), mem[16 + i], 32'hB0 + 32'(i));
        chk("rstb_mem3_untouched", mem[19], 32'h0);
        @(negedge clk);
        chk("rstb_idle_stall", cpu_stall, 0);
        chk("rstb_idle_ack", dbg_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
